// File: rtl/handshake_tx.sv
// handshake_tx: single-word 4-phase (return-to-zero) request/acknowledge
// transmitter toward an asynchronous receiver.
//
// - ack passes through a SYNC_STAGES flop chain; only the last stage (ack_s)
//   feeds logic.
// - The local side hands over a word with send_valid/send_ready. The word is
//   latched onto data_out and held while req is high and until the cycle
//   returns to IDLE.
// - Optional feature macro HANDSHAKE_TX_TIMEOUT_EN: adds a per-state watchdog
//   counter that aborts a stalled handshake with an err pulse. Without the
//   macro, err is tied low and the FSM waits indefinitely.
module handshake_tx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send_valid,
    input  logic [WIDTH-1:0] send_data,
    output logic             send_ready,
    output logic             req,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic               ack_s;
    logic               req_r;
    logic               req_next_s;
    logic               done_r;
    logic               done_next_s;
    logic               err_r;
    logic               err_next_s;
    logic               ready_r;
    logic               load_s;
    logic [WIDTH-1:0]   data_r;
    logic               timeout_s;
    logic               abort_s;

    // Synchronize the asynchronous acknowledge into the clk domain
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], ack};
        end
    end

    assign ack_s = sync_r[SYNC_STAGES-1];

`ifdef HANDSHAKE_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             abort_r;

    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES));
    assign abort_s   = abort_r;

    // Watchdog: restart on every state change, count while a handshake is open
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            cnt_r <= '0;
        end else if (state_r != IDLE) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Remember that the request phase was aborted so the release phase ends
    // without claiming a completed transfer
    always_ff @(posedge clk) begin
        if (!reset) begin
            abort_r <= 1'b0;
        end else if (state_r == REQ_HI && !ack_s && timeout_s) begin
            abort_r <= 1'b1;
        end else if (state_next_s == IDLE) begin
            abort_r <= 1'b0;
        end else begin
            abort_r <= abort_r;
        end
    end
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
    assign timeout_s        = 1'b0;
    assign abort_s          = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and next-output decode
    always_comb begin
        state_next_s = state_r;
        req_next_s   = req_r;
        done_next_s  = 1'b0;
        err_next_s   = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (send_valid && ready_r) begin
                    state_next_s = REQ_HI;
                    req_next_s   = 1'b1;
                    load_s       = 1'b1;
                end else begin
                    req_next_s   = 1'b0;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_next_s = REQ_LO;
                    req_next_s   = 1'b0;
                end else if (timeout_s) begin
                    state_next_s = REQ_LO;
                    req_next_s   = 1'b0;
                    err_next_s   = 1'b1;
                end else begin
                    req_next_s   = 1'b1;
                end
            end
            REQ_LO: begin
                req_next_s = 1'b0;
                if (!ack_s) begin
                    state_next_s = IDLE;
                    done_next_s  = !abort_s;
                end else if (timeout_s) begin
                    state_next_s = IDLE;
                    err_next_s   = 1'b1;
                end else begin
                    state_next_s = REQ_LO;
                end
            end
            default: begin
                state_next_s = IDLE;
                req_next_s   = 1'b0;
            end
        endcase
    end

    // Registered outputs; ready follows the state being entered so it is low
    // during reset and rises together with done
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_r   <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b0;
            data_r  <= '0;
        end else begin
            req_r   <= req_next_s;
            done_r  <= done_next_s;
            err_r   <= err_next_s;
            ready_r <= (state_next_s == IDLE);
            if (load_s) begin
                data_r <= send_data;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign send_ready = ready_r;
    assign req        = req_r;
    assign data_out   = data_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_handshake_tx.sv
// Directed self-checking bench for handshake_tx (WIDTH=8, SYNC_STAGES=2,
// TIMEOUT_CYCLES=16). Honours HANDSHAKE_TX_TIMEOUT_EN for the watchdog case.
module tb_handshake_tx;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       send_valid = 1'b0;
    logic [7:0] send_data  = 8'h00;
    logic       ack        = 1'b0;
    logic       send_ready;
    logic       req;
    logic [7:0] data_out;
    logic       done;
    logic       err;

    int chk_cnt     = 0;
    int pass_cnt    = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int overlap_cnt = 0;

    handshake_tx #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .send_valid(send_valid),
        .send_data(send_data),
        .send_ready(send_ready),
        .req(req),
        .data_out(data_out),
        .ack(ack),
        .done(done),
        .err(err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Event monitor sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (req && send_ready) overlap_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        int n = 0;
        while (req !== lvl && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(req), 32'(lvl));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    logic [7:0] words [3] = '{8'h01, 8'h02, 8'h03};

    initial begin
        int d0;
        int e0;
        int bad;

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(send_ready), 32'd0);
        reset = 1'b1;
        tick();
        check("rst_release_ready", 32'(send_ready), 32'd1);

        // Basic transfer with exact latencies
        d0 = done_cnt;
        send_data  = 8'hA5;
        send_valid = 1'b1;
        tick();
        check("basic_req_rise", 32'(req), 32'd1);
        check("basic_data", 32'(data_out), 32'hA5);
        check("basic_ready_low", 32'(send_ready), 32'd0);
        send_valid = 1'b0;
        send_data  = 8'h00;
        tick();
        tick();
        ack = 1'b1;
        tick();
        check("basic_req_k", 32'(req), 32'd1);
        tick();
        check("basic_req_k1", 32'(req), 32'd1);
        check("basic_data_hold", 32'(data_out), 32'hA5);
        tick();
        check("basic_req_fall_k2", 32'(req), 32'd0);
        check("basic_no_early_done", 32'(done), 32'd0);
        tick();
        tick();
        ack = 1'b0;
        tick();
        tick();
        check("basic_done_m1", 32'(done), 32'd0);
        tick();
        check("basic_done_m2", 32'(done), 32'd1);
        check("basic_ready_with_done", 32'(send_ready), 32'd1);
        tick();
        check("basic_done_one_pulse", 32'(done), 32'd0);
        check("basic_done_count", 32'(done_cnt - d0), 32'd1);

        // Back-to-back stream
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            send_data  = words[i];
            send_valid = 1'b1;
            wait_req(1'b1, "stream_req_hi");
            check("stream_word", 32'(data_out), 32'(words[i]));
            send_valid = (i < 2);
            ack = 1'b1;
            wait_req(1'b0, "stream_req_lo");
            ack = 1'b0;
            wait_done("stream_done");
            check("stream_ready_at_done", 32'(send_ready), 32'd1);
        end
        send_valid = 1'b0;
        tick();
        check("stream_done_count", 32'(done_cnt - d0), 32'd3);
        check("stream_no_ready_with_req", 32'(overlap_cnt), 32'd0);

        // Reset mid-transfer
        d0 = done_cnt;
        e0 = err_cnt;
        send_data  = 8'h3C;
        send_valid = 1'b1;
        tick();
        check("mid_req_hi", 32'(req), 32'd1);
        send_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("mid_req_dropped", 32'(req), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        check("mid_ready_in_rst", 32'(send_ready), 32'd0);
        check("mid_data_cleared", 32'(data_out), 32'd0);
        reset = 1'b1;
        tick();
        check("mid_ready_after", 32'(send_ready), 32'd1);
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_no_err", 32'(err_cnt - e0), 32'd0);

        // Ignored input while the request is open
        d0 = done_cnt;
        send_data  = 8'h5A;
        send_valid = 1'b1;
        tick();
        check("ign_req_hi", 32'(req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_valid = i[0];
            send_data  = 8'hF0 + 8'(i);
            tick();
        end
        check("ign_data_held", 32'(data_out), 32'h5A);
        check("ign_req_still_hi", 32'(req), 32'd1);
        send_valid = 1'b0;
        ack = 1'b1;
        wait_req(1'b0, "ign_req_lo");
        ack = 1'b0;
        wait_done("ign_done");
        repeat (3) tick();
        check("ign_no_extra_req", 32'(req), 32'd0);
        check("ign_data_idle_hold", 32'(data_out), 32'h5A);
        check("ign_done_count", 32'(done_cnt - d0), 32'd1);

`ifdef HANDSHAKE_TX_TIMEOUT_EN
        // Watchdog abort: receiver never acknowledges
        d0 = done_cnt;
        e0 = err_cnt;
        bad = 0;
        send_data  = 8'h77;
        send_valid = 1'b1;
        tick();
        check("to_req_hi", 32'(req), 32'd1);
        send_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (req !== 1'b1 || err !== 1'b0) bad++;
        end
        check("to_req_held_16", 32'(bad), 32'd0);
        tick();
        check("to_req_fall", 32'(req), 32'd0);
        check("to_err_pulse", 32'(err), 32'd1);
        tick();
        check("to_err_single", 32'(err), 32'd0);
        check("to_idle_ready", 32'(send_ready), 32'd1);
        check("to_no_done_now", 32'(done), 32'd0);
        repeat (3) tick();
        check("to_err_count", 32'(err_cnt - e0), 32'd1);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
`else
        // No watchdog: the request stays open indefinitely
        bad = 0;
        send_data  = 8'h99;
        send_valid = 1'b1;
        tick();
        check("nto_req_hi", 32'(req), 32'd1);
        send_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (req !== 1'b1 || err !== 1'b0) bad++;
        end
        check("nto_stable_1000", 32'(bad), 32'd0);
        check("nto_err_count", 32'(err_cnt), 32'd0);
        check("nto_data_held", 32'(data_out), 32'h99);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
